// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment bit
// positions, the hex font and the scan FSM state type.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs {g,f,e,d,c,b,a}, indexed by nibble value
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph lookup with a blanking override; output is
// active-high, polarity is applied by the caller.
module seg7_hex_decode (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);
  import seg7_pkg::*;

  // Font lookup, forced dark when the digit is blanked
  always_comb begin
    seg = 7'h00;
    if (blank) begin
      seg = 7'h00;
    end else begin
      seg = HEX_FONT[nibble];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex display driver with double-buffered value,
// per-slot dead time, leading-zero blanking and configurable pin polarity.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEAD_CYCLES    = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);
  import seg7_pkg::*;

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  scan_state_e state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [IDX_W-1:0] idx_r, idx_next_s;
  logic wrap_s;

  logic [4*NUM_DIGITS-1:0] pending_r, display_r;
  logic [NUM_DIGITS-1:0]   pending_dp_r, disp_dp_r;
  logic                    pending_valid_r;

  logic [3:0]            nibble_s;
  logic                  blank_s, dp_s, lit_s;
  logic [6:0]            seg_raw_s;
  logic [NUM_DIGITS-1:0] anode_s;

  // Next-state, slot counter and frame-wrap detection
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    idx_next_s   = idx_r;
    wrap_s       = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_next_s = '0;
        idx_next_s = '0;
        if (enable) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
          idx_next_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          cnt_next_s = '0;
          if (idx_r == IDX_LAST) begin
            idx_next_s = '0;
            wrap_s     = 1'b1;
          end else begin
            idx_next_s = idx_r + 1'b1;
          end
        end else begin
          cnt_next_s = cnt_r + 1'b1;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
        idx_next_s   = '0;
      end
    endcase
  end

  // Scan FSM state and position registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Double buffer: display only changes at a frame boundary while scanning
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r       <= '0;
      pending_dp_r    <= '0;
      pending_valid_r <= 1'b0;
      display_r       <= '0;
      disp_dp_r       <= '0;
    end else if (state_r == IDLE) begin
      if (load) begin
        display_r       <= value;
        disp_dp_r       <= dp_in;
        pending_valid_r <= 1'b0;
      end
    end else if (wrap_s) begin
      if (load) begin
        display_r <= value;
        disp_dp_r <= dp_in;
      end else if (pending_valid_r) begin
        display_r <= pending_r;
        disp_dp_r <= pending_dp_r;
      end
      pending_valid_r <= 1'b0;
    end else if (load) begin
      pending_r       <= value;
      pending_dp_r    <= dp_in;
      pending_valid_r <= 1'b1;
    end
  end

  // Select the current digit and decide leading-zero blanking from the top down
  always_comb begin
    logic zero_run;
    logic sel;
    nibble_s = 4'h0;
    dp_s     = 1'b0;
    blank_s  = 1'b0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (display_r[4*i +: 4] == 4'h0);
      sel      = (idx_r == IDX_W'(i));
      nibble_s = sel ? display_r[4*i +: 4] : nibble_s;
      dp_s     = sel ? disp_dp_r[i] : dp_s;
      blank_s  = sel ? (blank_lz && zero_run && (i > 0)) : blank_s;
    end
  end

  seg7_hex_decode u_dec (
    .nibble (nibble_s),
    .blank  (blank_s),
    .seg    (seg_raw_s)
  );

  // Anode select: lit only in SCAN past the dead-time window
  always_comb begin
    lit_s = (state_r == SCAN) && (cnt_r >= DEAD_END);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_s[i] = lit_s && (idx_r == IDX_W'(i));
    end
  end

  // Registered pin outputs with polarity applied last
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode      <= {NUM_DIGITS{AN_INV}};
      seg        <= {7{SEG_INV}};
      seg_dp     <= SEG_INV;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_s ^ {NUM_DIGITS{AN_INV}};
      seg        <= (lit_s ? seg_raw_s : 7'h00) ^ {7{SEG_INV}};
      seg_dp     <= (lit_s && dp_s) ^ SEG_INV;
      frame_done <= wrap_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based display model feeds
// expected pin values into queues that a separate monitor drains and checks.
module tb_seg7_scan_driver;

  localparam int S    = 8;
  localparam int DEAD = 1;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable   = 1'b0;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value    = 16'h0000;
  logic [3:0]  dp_in    = 4'h0;

  logic [6:0] seg0, seg1;
  logic       sdp0, sdp1, fd0, fd1;
  logic [3:0] an0;
  logic [2:0] an1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(S), .DEAD_CYCLES(DEAD),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg0), .seg_dp(sdp0),
    .anode(an0), .frame_done(fd0)
  );

  seg7_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(S), .DEAD_CYCLES(DEAD),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value[11:0]),
    .dp_in(dp_in[2:0]), .blank_lz(blank_lz), .seg(seg1), .seg_dp(sdp1),
    .anode(an1), .frame_done(fd1)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       chk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: running flag, cycles since scan start, shown and pending frames
  bit          m_run  [2];
  int          m_t    [2];
  logic [31:0] m_disp [2];
  logic [31:0] m_pend [2];
  logic [7:0]  m_dp   [2];
  logic [7:0]  m_pdp  [2];
  bit          m_pv   [2];

  function automatic int ndig(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic exp_t model_out(int k);
    exp_t e;
    int n, ph, dig;
    logic [31:0] rest;
    n = ndig(k);
    e.an = 8'h00; e.seg = 7'h00; e.dp = 1'b0; e.fd = 1'b0; e.chk = 1'b1;
    if (rst_n && m_run[k]) begin
      ph    = m_t[k] % S;
      dig   = (m_t[k] / S) % n;
      e.fd  = enable && ((m_t[k] % (S * n)) == (S * n - 1));
      if (ph < DEAD) begin
        e.chk = 1'b0;
      end else begin
        e.an[dig] = 1'b1;
        rest  = m_disp[k] >> (4 * dig);
        e.seg = (blank_lz && dig > 0 && rest == 32'h0) ? 7'h00 : font[rest[3:0]];
        e.dp  = m_dp[k][dig];
      end
    end
    if (k == 0) begin
      e.an = e.an ^ 8'h0F;
    end else begin
      e.seg = e.seg ^ 7'h7F;
      e.dp  = ~e.dp;
    end
    return e;
  endfunction

  function automatic void model_step(int k);
    int n;
    bit wrap;
    logic [31:0] v;
    logic [7:0]  dm;
    n  = ndig(k);
    v  = {16'h0000, value} & ((32'h1 << (4 * n)) - 32'h1);
    dm = {4'h0, dp_in} & ((8'h1 << n) - 8'h1);
    if (!rst_n) begin
      m_run[k] = 0; m_t[k] = 0; m_disp[k] = 0; m_pend[k] = 0;
      m_dp[k] = 0; m_pdp[k] = 0; m_pv[k] = 0;
    end else if (!m_run[k]) begin
      if (load) begin m_disp[k] = v; m_dp[k] = dm; m_pv[k] = 0; end
      if (enable) begin m_run[k] = 1; m_t[k] = 0; end
    end else begin
      wrap = enable && ((m_t[k] % (S * n)) == (S * n - 1));
      if (wrap) begin
        if (load) begin m_disp[k] = v; m_dp[k] = dm; end
        else if (m_pv[k]) begin m_disp[k] = m_pend[k]; m_dp[k] = m_pdp[k]; end
        m_pv[k] = 0;
      end else if (load) begin
        m_pend[k] = v; m_pdp[k] = dm; m_pv[k] = 1;
      end
      if (!enable) m_run[k] = 0;
      else m_t[k] = m_t[k] + 1;
    end
  endfunction

  // Reference: predict what each edge should put on the pins, then advance
  always @(posedge clk) begin
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int k);
    exp_t e;
    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL queue_empty u%0d @%0t: got 0 entries expected 1", k, $time);
      return;
    end
    if (k == 0) begin
      e = q0.pop_front();
      cmp("anode", 0, {4'h0, an0}, e.an);
      cmp("frame_done", 0, {7'h00, fd0}, {7'h00, e.fd});
      if (e.chk) begin
        cmp("seg", 0, {1'b0, seg0}, {1'b0, e.seg});
        cmp("seg_dp", 0, {7'h00, sdp0}, {7'h00, e.dp});
      end
    end else begin
      e = q1.pop_front();
      cmp("anode", 1, {5'h00, an1}, e.an);
      cmp("frame_done", 1, {7'h00, fd1}, {7'h00, e.fd});
      if (e.chk) begin
        cmp("seg", 1, {1'b0, seg1}, {1'b0, e.seg});
        cmp("seg_dp", 1, {7'h00, sdp1}, {7'h00, e.dp});
      end
    end
  endtask

  // Monitor: compare pins shortly after each edge against the scoreboard
  always @(posedge clk) begin
    #1;
    check_inst(0);
    check_inst(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 200; i++) begin
      if (m_run[0] && (m_t[0] % (4 * S)) == ph) return;
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_phase: got no frame position %0d expected within 200 cycles", ph);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    do_load(16'h3210, 4'b0100);
    enable = 1'b1;
    cyc(64);
    do_load(16'h0040, 4'h0);
    blank_lz = 1'b1;
    cyc(80);
    blank_lz = 1'b0;
    cyc(40);
    do_load(16'h0000, 4'h0);
    cyc(40);
    wait_phase(S + 3);
    do_load(16'hFFFF, 4'hF);
    cyc(40);
    wait_phase(4 * S - 1);
    do_load(16'h1234, 4'h5);
    cyc(40);
    do_load(16'h38A5, 4'h2);
    cyc(80);
    wait_phase(2 * S + 2);
    enable = 1'b0;
    cyc(5);
    enable = 1'b1;
    cyc(40);
    wait_phase(2 * S + 4);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(40);
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(15) == 0);
      if (load) begin
        value = 16'($urandom);
        dp_in = 4'($urandom);
      end
      if ($urandom_range(63) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(199) == 0) enable = ~enable;
      rst_n = ($urandom_range(499) != 0);
      @(negedge clk);
    end
    load = 1'b0; rst_n = 1'b1; enable = 1'b0;
    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
